// File: rtl/vga_pkg.sv
// Shared map ROM widths and types for the game video block.
// Address is {row[5:0], col[7:0]}; data is one 12-bit pixel word.
package vga_pkg;
  localparam int MAP_ADR_W  = 14;
  localparam int MAP_DATA_W = 12;

  typedef logic [MAP_ADR_W-1:0]  map_adr_t;
  typedef logic [MAP_DATA_W-1:0] map_data_t;
endpackage

// File: rtl/map_arb_rr_pick.sv
// Rotate-priority encoder: first set request at or above the pointer,
// wrapping to 0; returns one-hot winner, its index and a found flag.
module map_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  int w_p;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_p     = 0;
    for (int k = 0; k < N; k++) begin
      w_p = int'(i_ptr) + k;
      if (w_p >= N) w_p = w_p - N;
      if (!o_found && i_req[w_p]) begin
        o_found    = 1'b1;
        o_gnt[w_p] = 1'b1;
        o_idx      = IW'(w_p);
      end
    end
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// Round-robin arbiter with lock bursts sharing the level-map ROM.
// Define MAP_ARB_PRIO_EN to give requester 0 absolute priority.
module map_rom_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0]                     lock,
  input  logic [N_REQ-1:0][MAP_ADR_W-1:0]      adr,
  output logic [N_REQ-1:0]                     gnt,
  output logic [N_REQ-1:0][MAP_DATA_W-1:0]     rdata,
  output logic [N_REQ-1:0]                     rdata_valid,
  output map_adr_t                             rom_adr,
  input  map_data_t                            rom_data
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0] r_ptr;
  logic          r_own_vld;
  logic [IW-1:0] r_own_id;
  logic [CW-1:0] r_cnt;
  logic          r_excl_vld;
  logic [IW-1:0] r_excl_id;

  logic [ROM_LAT:0]  r_pv;
  logic [IW-1:0]     r_pid [ROM_LAT+1];

  logic [N_REQ-1:0] w_excl;
  logic [N_REQ-1:0] w_req_m;
  logic [N_REQ-1:0] w_rr_gnt;
  logic [IW-1:0]    w_rr_idx;
  logic             w_rr_found;
  logic             w_own_win;
  logic             w_found;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_keep;
  logic             w_hit_max;

  map_arb_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (w_req_m),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  always_comb begin
    w_excl = '0;
    if (r_excl_vld) w_excl[r_excl_id] = 1'b1;
    w_req_m   = req & ~w_excl;
    w_own_win = r_own_vld && req[r_own_id] &&
                (r_cnt < CW'(MAX_BURST));
    w_found = w_rr_found;
    w_idx   = w_rr_idx;
    if (w_own_win) begin
      w_found = 1'b1;
      w_idx   = r_own_id;
    end
`ifdef MAP_ARB_PRIO_EN
    if (w_req_m[0]) begin
      w_found = 1'b1;
      w_idx   = '0;
    end
`endif
    w_gnt = '0;
    if (w_found) w_gnt[w_idx] = 1'b1;
  end

  assign gnt = w_gnt;

  // Count continues only when the same owner is granted again
  always_comb begin
    w_cnt_inc = ((r_own_vld && r_own_id == w_idx) ? r_cnt : '0)
              + CW'(1);
    w_keep    = w_found && lock[w_idx] &&
                (w_cnt_inc < CW'(MAX_BURST));
    w_hit_max = w_found && lock[w_idx] &&
                (w_cnt_inc >= CW'(MAX_BURST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_own_vld  <= 1'b0;
      r_own_id   <= '0;
      r_cnt      <= '0;
      r_excl_vld <= 1'b0;
      r_excl_id  <= '0;
      rom_adr    <= '0;
    end else begin
      if (w_found) begin
        rom_adr <= adr[w_idx];
`ifdef MAP_ARB_PRIO_EN
        if (w_idx != '0)
`endif
          r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      r_own_vld  <= w_keep;
      r_own_id   <= w_idx;
      r_cnt      <= w_keep ? w_cnt_inc : '0;
      r_excl_vld <= w_hit_max;
      r_excl_id  <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int s = 0; s <= ROM_LAT; s++) r_pid[s] <= '0;
      rdata       <= '0;
      rdata_valid <= '0;
    end else begin
      r_pv[0]  <= w_found;
      r_pid[0] <= w_idx;
      for (int s = 1; s <= ROM_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
      rdata_valid <= '0;
      if (r_pv[ROM_LAT]) begin
        rdata_valid[r_pid[ROM_LAT]] <= 1'b1;
        rdata[r_pid[ROM_LAT]]       <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a read-return scoreboard.
module tb_map_rom_arbiter;
  import vga_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [3:0]            req;
  logic [3:0]            lock;
  logic [3:0][13:0]      adr;
  logic [3:0]            gnt;
  logic [3:0][11:0]      rdata;
  logic [3:0]            rdata_valid;
  map_adr_t              rom_adr;
  map_data_t             rom_data;

  typedef struct {
    int        id;
    logic [11:0] d;
    int        c;
  } exp_t;

  exp_t      q[$];
  int        checks;
  int        errors;
  int        cyc;
  logic [13:0] exp_rom;

  map_rom_arbiter #(
    .N_REQ     (4),
    .ROM_LAT   (1),
    .MAX_BURST (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .adr         (adr),
    .gnt         (gnt),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rom_adr     (rom_adr),
    .rom_data    (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [13:0] a);
    return a[11:0] ^ {a[13:12], a[13:12], 8'h5A};
  endfunction

  always @(posedge clk) begin
    rom_data <= rom_f(rom_adr);
    cyc      <= cyc + 1;
  end

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdata_valid != 4'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid=%b at cyc %0d, required none",
                 rdata_valid, cyc);
      end else begin
        e = q.pop_front();
        if (rdata_valid != 4'(1 << e.id) || rdata[e.id] != e.d
            || cyc != e.c) begin
          errors++;
          $display("FAIL return: got valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                   rdata_valid, rdata[e.id], cyc, 4'(1 << e.id), e.d, e.c);
        end
      end
    end else if (q.size() != 0 && cyc > q[0].c) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missing_valid: got no pulse by cyc %0d, required id %0d at cyc %0d",
               cyc, e.id, e.c);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] eg, input string nm);
    exp_t e;
    int   k;
    req  = r;
    lock = l;
    for (int i = 0; i < 4; i++)
      adr[i] = {2'(i), 12'(cyc * 5 + i * 3)};
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(gnt), 64'(eg));
    if (eg != 4'b0) begin
      k       = oh2i(eg);
      e.id    = k;
      e.d     = rom_f(adr[k]);
      e.c     = cyc + 3;
      q.push_back(e);
      exp_rom = adr[k];
    end
    @(posedge clk);
    #1;
    chk({nm, "_rom_adr"}, 64'(rom_adr), 64'(exp_rom));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    exp_rom = '0;
    rst     = 1'b1;
    req     = '0;
    lock    = '0;
    adr     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_valid", 64'(rdata_valid), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    chk("reset_rom_adr", 64'(rom_adr), 64'h0);
    @(posedge clk);
    #1;

    // single request, pointer 0 -> 3
    step(4'b0100, 4'b0000, 4'b0100, "single");
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, "drain1");

    // all held, starting at pointer 3
    step(4'b1111, 4'b0000, 4'b1000, "all0");
    step(4'b1111, 4'b0000, 4'b0001, "all1");
    step(4'b1111, 4'b0000, 4'b0010, "all2");
    step(4'b1111, 4'b0000, 4'b0100, "all3");
    step(4'b1111, 4'b0000, 4'b1000, "all4");
    step(4'b1111, 4'b0000, 4'b0001, "all5");
    step(4'b1111, 4'b0000, 4'b0010, "all6");
    step(4'b1111, 4'b0000, 4'b0100, "all7");
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, "drain2");

    // wrap 3 -> 0
    step(4'b1001, 4'b0000, 4'b1000, "wrap0");
    step(4'b1001, 4'b0000, 4'b0001, "wrap1");
    step(4'b0110, 4'b0000, 4'b0010, "wrap2");
    step(4'b0110, 4'b0000, 4'b0100, "wrap3");

    // lock burst of 8 on requester 1 while 3 waits
    step(4'b1000, 4'b0000, 4'b1000, "pre_lock");
    for (int i = 0; i < 8; i++)
      step(4'b1010, 4'b0010, 4'b0010, "burst");
    step(4'b1010, 4'b0010, 4'b1000, "burst_yield");
    step(4'b1010, 4'b0010, 4'b0010, "burst_resume0");
    step(4'b1010, 4'b0010, 4'b0010, "burst_resume1");
    step(4'b1010, 4'b0010, 4'b0010, "burst_resume2");
    step(4'b0000, 4'b0000, 4'b0000, "unlock");

    // requester 0 against a lock owned by 2
    step(4'b0100, 4'b0100, 4'b0100, "lock2");
`ifdef MAP_ARB_PRIO_EN
    step(4'b0101, 4'b0100, 4'b0001, "prio0");
    step(4'b0101, 4'b0100, 4'b0001, "prio1");
`else
    step(4'b0101, 4'b0100, 4'b0100, "prio0");
    step(4'b0101, 4'b0100, 4'b0100, "prio1");
`endif
    step(4'b0100, 4'b0000, 4'b0100, "lock2_end");

    // idle: no grants, rom_adr holds, no stray pulses
    for (int i = 0; i < 10; i++)
      step(4'b0000, 4'b0000, 4'b0000, "idle");
    chk("drained", 64'(q.size()), 64'h0);

    // reset one cycle after a grant (pointer 3 -> finds 1)
    step(4'b0010, 4'b0000, 4'b0010, "rst_pre");
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    q.delete();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_rom = '0;
    @(negedge clk);
    chk("rst_rom_adr", 64'(rom_adr), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_valid", 64'(rdata_valid), 64'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      step(4'b0000, 4'b0000, 4'b0000, "post_rst");
    step(4'b1010, 4'b0000, 4'b0010, "ptr_reset");
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, "drain3");
    chk("final_drained", 64'(q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_rom_arbiter.md
# map_rom_arbiter

Shares the single-port level-map ROM (14-bit address = {row[5:0], col[7:0]}, 12-bit pixel word) between the game's map readers: player X/Y control collision probes, enemy logic and the background renderer. Round-robin arbitration, one ROM read issued per cycle, with optional short lock bursts for footprint scans. Read data is returned per requester through a fixed-latency valid pulse and a holding register. Sits between the game controllers and the map ROM instance in the top-level game block.

## Interface
- N_REQ, 4: number of requesters, 2..8
- ROM_LAT, 1: ROM read latency in cycles; `rom_data` corresponds to `rom_adr` presented ROM_LAT cycles earlier, 1..3
- MAX_BURST, 8: maximum consecutive locked grants to one requester, 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  read request per requester; held with `adr` until granted
- lock  in  N_REQ  request the next grant as well (burst); sampled only together with `gnt`
- adr  in  N_REQ x 14  packed array, map address per requester
- gnt  out  N_REQ  one-hot or zero, combinational, same cycle as winning `req`
- rdata  out  N_REQ x 12  last pixel word returned to each requester
- rdata_valid  out  N_REQ  one-cycle pulse when `rdata[i]` updates
- rom_adr  out  14  registered ROM address
- rom_data  in  12  ROM read data

## Operation
- Reset values: `gnt`=0, `rdata`=all 0, `rdata_valid`=0, `rom_adr`=0, RR pointer=0, burst counter=0, lock owner none, read pipeline cleared.
- Arbitration each cycle over `req`: lock owner wins if its `req` is high and burst count < MAX_BURST; otherwise first requester with `req` high searching from RR pointer upward, wrapping N_REQ-1 -> 0.
- On grant to i: `rom_adr` <= `adr[i]`; pipeline entry {valid, id=i} pushed; RR pointer <= i+1 mod N_REQ.
- Lock: if `lock[i]` high while `gnt[i]`, i becomes lock owner and burst counter increments; owner drops when `req[i]` or `lock[i]` low at grant, or counter reaches MAX_BURST; counter resets to 0 on release. A requester released at MAX_BURST is excluded from the following cycle's arbitration.
- No request: `gnt`=0, `rom_adr` holds, null entry pushed.
- Return: pipeline entry leaving after ROM_LAT+1 stages with valid=1 writes `rom_data` into `rdata[id]` and pulses `rdata_valid[id]`. `rdata[j]` for other j unchanged.
- Reset mid-flight: all pending reads discarded, no `rdata_valid` after reset deasserts until new grants complete.

## Timing
- `req[i]` high in cycle t, wins -> `gnt[i]` in cycle t; `rom_adr` updated in t+1; `rdata_valid[i]` and new `rdata[i]` in cycle t+2+ROM_LAT (t+3 default).
- Requester must drop or change `req`/`adr` on the edge after seeing `gnt`; holding `req` high means a new request.
- Throughput one read per cycle; returns in grant order, never reordered.
- Locked burst of k reads: k consecutive `gnt` cycles, k consecutive valid pulses.

## Configuration
- `MAP_ARB_PRIO_EN` defined: requester 0 (renderer) has absolute priority; its `req` wins over RR and over any other lock owner, breaking that lock (counter cleared); RR pointer not advanced by requester 0 grants.
- Undefined: pure round-robin plus lock as above; requester 0 treated like the others.

## Structure
- `vga_pkg`: MAP_ADR_W=14, MAP_DATA_W=12, typedefs `map_adr_t`, `map_data_t`.
- Sub-module `map_arb_rr_pick`: combinational rotate-priority encoder (req mask, pointer -> one-hot winner, found flag). Pipeline, lock and return registers stay in the top module.

## Test plan
- Single req[2], adr=0x1234, ROM model 1 cycle -> gnt[2] same cycle, rom_adr=0x1234 next cycle, rdata_valid[2] 3 cycles after gnt with ROM word for 0x1234.
- All four req held continuously -> grants 0,1,2,3,0,... one per cycle; each requester gets its data in order.
- req[1] with lock held 12 cycles, req[3] also pending -> 8 consecutive gnt[1], then gnt[3], then gnt[1] resumes.
- With `MAP_ARB_PRIO_EN`: req[0] asserted during requester 2 lock -> gnt[0] that cycle, lock broken; without the macro gnt[2] continues.
- rst asserted one cycle after a grant -> no rdata_valid afterwards, all outputs at reset values.
- No requests for 10 cycles -> gnt=0, rom_adr holds, no valid pulses; pointer wrap 3 -> 0 checked.
